// File: rtl/ysyx_22041752_icache_nway_pkg.sv
// Shared configuration for the N-way instruction cache: default parameters,
// FSM state encoding and the helpers that derive address-field widths.
package ysyx_22041752_icache_nway_pkg;

    localparam int DEF_WAYS        = 2;
    localparam int DEF_SETS        = 64;
    localparam int DEF_LINE_BYTES  = 16;
    localparam int DEF_ADDR_WD     = 32;
    localparam int DEF_MEM_DATA_WD = 64;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_REQ    = 3'd2,
        S_REFILL = 3'd3,
        S_RESP   = 3'd4
    } state_e;

    // Width of a counter/index that must be at least one bit wide.
    function automatic int clog2_min1(input int v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

    function automatic int offset_wd(input int line_bytes);
        return $clog2(line_bytes);
    endfunction

    function automatic int index_wd(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_wd(input int addr_wd, input int sets, input int line_bytes);
        return addr_wd - $clog2(sets) - $clog2(line_bytes);
    endfunction

    function automatic int beat_cnt_wd(input int line_bytes, input int mem_data_wd);
        return clog2_min1(line_bytes * 8 / mem_data_wd);
    endfunction

endpackage

// File: rtl/ysyx_22041752_icache_way.sv
// One cache way: valid bits (flash-clearable), tag and line arrays with a
// registered read port and a whole-line write port.
module ysyx_22041752_icache_way #(
    parameter int SETS     = 64,
    parameter int INDEX_WD = 6,
    parameter int TAG_WD   = 22,
    parameter int LINE_WD  = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush_i,
    input  logic [INDEX_WD-1:0] rd_idx_i,
    output logic                rd_valid_o,
    output logic [TAG_WD-1:0]   rd_tag_o,
    output logic [LINE_WD-1:0]  rd_line_o,
    input  logic                wr_en_i,
    input  logic [INDEX_WD-1:0] wr_idx_i,
    input  logic [TAG_WD-1:0]   wr_tag_i,
    input  logic [LINE_WD-1:0]  wr_line_i
);

    logic [SETS-1:0]    valid_q;
    logic [TAG_WD-1:0]  tag_mem  [SETS];
    logic [LINE_WD-1:0] line_mem [SETS];
    logic               rd_valid_q;
    logic [TAG_WD-1:0]  rd_tag_q;
    logic [LINE_WD-1:0] rd_line_q;

    // Flush wins over a coincident install so the line ends invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= valid_q[rd_idx_i];
            if (flush_i)
                valid_q <= '0;
            else if (wr_en_i)
                valid_q[wr_idx_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_mem[wr_idx_i]  <= wr_tag_i;
            line_mem[wr_idx_i] <= wr_line_i;
        end
        rd_tag_q  <= tag_mem[rd_idx_i];
        rd_line_q <= line_mem[rd_idx_i];
    end

    assign rd_valid_o = rd_valid_q;
    assign rd_tag_o   = rd_tag_q;
    assign rd_line_o  = rd_line_q;

endmodule

// File: rtl/ysyx_22041752_icache_nway.sv
// N-way set-associative instruction cache with single-request line refill,
// lowest-invalid / round-robin replacement and whole-cache flush.
module ysyx_22041752_icache_nway
    import ysyx_22041752_icache_nway_pkg::*;
#(
    parameter int WAYS        = DEF_WAYS,
    parameter int SETS        = DEF_SETS,
    parameter int LINE_BYTES  = DEF_LINE_BYTES,
    parameter int ADDR_WD     = DEF_ADDR_WD,
    parameter int MEM_DATA_WD = DEF_MEM_DATA_WD
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   inst_en,
    input  logic [ADDR_WD-1:0]     inst_addr,
    output logic [31:0]            inst_rdata,
    output logic                   inst_valid,
    output logic                   cache_miss,
    output logic                   sram_req,
    input  logic                   sram_ready,
    output logic [ADDR_WD-1:0]     sram_addr,
    input  logic [MEM_DATA_WD-1:0] sram_rdata,
    input  logic                   sram_valid
);

    localparam int OFFSET_WD   = offset_wd(LINE_BYTES);
    localparam int INDEX_WD    = index_wd(SETS);
    localparam int TAG_WD      = tag_wd(ADDR_WD, SETS, LINE_BYTES);
    localparam int BEAT_CNT_WD = beat_cnt_wd(LINE_BYTES, MEM_DATA_WD);
    localparam int BEATS       = LINE_BYTES * 8 / MEM_DATA_WD;
    localparam int WAY_WD      = clog2_min1(WAYS);
    localparam int LINE_WD     = LINE_BYTES * 8;
    localparam int WORDS       = LINE_BYTES / 4;
    localparam int WSEL_WD     = OFFSET_WD - 2;

    state_e                         state_q;
    logic [ADDR_WD-1:2]             addr_q;
    logic [BEAT_CNT_WD-1:0]         beat_cnt_q;
    logic [LINE_WD-1:0]             line_q;
    logic                           drain_q;
    logic [WAY_WD-1:0]              victim_q;
    logic [SETS-1:0][WAY_WD-1:0]    rr_q;

    logic [WAYS-1:0]                way_vld;
    logic [WAYS-1:0]                way_hit;
    logic [WAYS-1:0]                way_wr;
    logic [WAYS-1:0][TAG_WD-1:0]    way_tag;
    logic [WAYS-1:0][LINE_WD-1:0]   way_line;

    logic [INDEX_WD-1:0]            cur_idx;
    logic [TAG_WD-1:0]              cur_tag;
    logic [WSEL_WD-1:0]             wsel;
    logic                           hit;
    logic [LINE_WD-1:0]             hit_line;
    logic [WAY_WD-1:0]              victim;
    logic [LINE_WD-1:0]             merged_line;
    logic                           last_beat;
    logic                           install;
    logic                           unused_addr_lsb;

    assign unused_addr_lsb = ^inst_addr[1:0];
    assign cur_idx = addr_q[OFFSET_WD+INDEX_WD-1:OFFSET_WD];
    assign cur_tag = addr_q[ADDR_WD-1:OFFSET_WD+INDEX_WD];
    assign wsel    = addr_q[OFFSET_WD-1:2];

    function automatic logic [31:0] pick_word(input logic [LINE_WD-1:0] ln,
                                              input logic [WSEL_WD-1:0] ws);
        logic [31:0] w;
        w = '0;
        for (int k = 0; k < WORDS; k++)
            if (ws == WSEL_WD'(k)) w = ln[k*32 +: 32];
        return w;
    endfunction

    genvar gw;
    for (gw = 0; gw < WAYS; gw++) begin : g_way
        ysyx_22041752_icache_way #(
            .SETS     (SETS),
            .INDEX_WD (INDEX_WD),
            .TAG_WD   (TAG_WD),
            .LINE_WD  (LINE_WD)
        ) u_way (
            .clk        (clk),
            .rst_n      (reset),
            .flush_i    (flush),
            .rd_idx_i   (inst_addr[OFFSET_WD+INDEX_WD-1:OFFSET_WD]),
            .rd_valid_o (way_vld[gw]),
            .rd_tag_o   (way_tag[gw]),
            .rd_line_o  (way_line[gw]),
            .wr_en_i    (way_wr[gw]),
            .wr_idx_i   (cur_idx),
            .wr_tag_i   (cur_tag),
            .wr_line_i  (merged_line)
        );
        assign way_hit[gw] = way_vld[gw] && (way_tag[gw] == cur_tag);
        assign way_wr[gw]  = install && (victim_q == WAY_WD'(gw));
    end

    always_comb begin
        hit      = |way_hit;
        hit_line = '0;
        victim   = rr_q[cur_idx];
        for (int w = 0; w < WAYS; w++)
            if (way_hit[w]) hit_line = hit_line | way_line[w];
        for (int w = WAYS - 1; w >= 0; w--)
            if (!way_vld[w]) victim = WAY_WD'(w);
    end

    always_comb begin
        merged_line = line_q;
        for (int b = 0; b < BEATS; b++)
            if (beat_cnt_q == BEAT_CNT_WD'(b))
                merged_line[b*MEM_DATA_WD +: MEM_DATA_WD] = sram_rdata;
    end

    assign last_beat = (beat_cnt_q == BEAT_CNT_WD'(BEATS - 1));
    assign install   = (state_q == S_REFILL) && sram_valid && last_beat && !drain_q && !flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            beat_cnt_q <= '0;
            line_q     <= '0;
            drain_q    <= 1'b0;
            victim_q   <= '0;
            rr_q       <= '0;
        end else begin
            if (flush && (state_q == S_REQ || state_q == S_REFILL))
                drain_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (inst_en && !flush) begin
                        state_q <= S_LOOKUP;
                        addr_q  <= inst_addr[ADDR_WD-1:2];
                    end
                end
                S_LOOKUP: begin
                    if (flush) begin
                        state_q <= S_IDLE;
                    end else if (hit) begin
                        state_q <= inst_en ? S_LOOKUP : S_IDLE;
                        if (inst_en) addr_q <= inst_addr[ADDR_WD-1:2];
                    end else begin
                        state_q  <= S_REQ;
                        victim_q <= victim;
                    end
                end
                S_REQ: begin
                    if (sram_ready) begin
                        state_q    <= S_REFILL;
                        beat_cnt_q <= '0;
                    end
                end
                S_REFILL: begin
                    if (sram_valid) begin
                        line_q <= merged_line;
                        if (last_beat) begin
                            beat_cnt_q <= '0;
                            drain_q    <= 1'b0;
                            if (install) begin
                                state_q       <= S_RESP;
                                rr_q[cur_idx] <= (rr_q[cur_idx] == WAY_WD'(WAYS - 1)) ?
                                                 '0 : rr_q[cur_idx] + 1'b1;
                            end else begin
                                state_q <= S_IDLE;
                            end
                        end else begin
                            beat_cnt_q <= beat_cnt_q + 1'b1;
                        end
                    end
                end
                S_RESP:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // The hit response is combinational: the tag compare needs the
    // registered array read, and the word must appear one cycle after inst_en.
    always_comb begin
        inst_valid = 1'b0;
        inst_rdata = '0;
        if (state_q == S_LOOKUP && hit) begin
            inst_valid = !flush;
            inst_rdata = pick_word(hit_line, wsel);
        end else if (state_q == S_RESP) begin
            inst_valid = !flush;
            inst_rdata = pick_word(line_q, wsel);
        end
    end

    assign cache_miss = ((state_q == S_LOOKUP) && !hit && !flush) ||
                        (state_q == S_REQ) || (state_q == S_REFILL);
    assign sram_req   = (state_q == S_REQ);
    assign sram_addr  = {addr_q[ADDR_WD-1:OFFSET_WD], {OFFSET_WD{1'b0}}};

endmodule

// File: tb/tb_ysyx_22041752_icache_nway.sv
// Randomised bench for the N-way icache against a set/way/round-robin model.
module tb_ysyx_22041752_icache_nway;

    logic        clk = 1'b0;
    logic        reset, flush, inst_en, sram_ready, sram_valid;
    logic [31:0] inst_addr, inst_rdata, sram_addr;
    logic        inst_valid, cache_miss, sram_req;
    logic [63:0] sram_rdata;

    ysyx_22041752_icache_nway dut (
        .clk(clk), .reset(reset), .flush(flush), .inst_en(inst_en),
        .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_valid(inst_valid),
        .cache_miss(cache_miss), .sram_req(sram_req), .sram_ready(sram_ready),
        .sram_addr(sram_addr), .sram_rdata(sram_rdata), .sram_valid(sram_valid)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural cache: 64 sets x 2 ways, 16-byte lines.
    bit           m_vld [64][2];
    logic [21:0]  m_tag [64][2];
    logic [127:0] m_line[64][2];
    int           m_rr  [64];

    function automatic bit m_lookup(input logic [31:0] a, output logic [31:0] w);
        int i, ws;
        i = int'((a >> 4) & 32'd63);
        ws = int'((a >> 2) & 32'd3);
        w = '0;
        for (int j = 0; j < 2; j++)
            if (m_vld[i][j] && m_tag[i][j] == a[31:10]) begin
                w = m_line[i][j][ws*32 +: 32];
                return 1'b1;
            end
        return 1'b0;
    endfunction

    function automatic void m_fill(input logic [31:0] a, input logic [127:0] ln);
        int i, way;
        i = int'((a >> 4) & 32'd63);
        way = -1;
        for (int j = 1; j >= 0; j--) if (!m_vld[i][j]) way = j;
        if (way < 0) way = m_rr[i];
        m_vld[i][way]  = 1'b1;
        m_tag[i][way]  = a[31:10];
        m_line[i][way] = ln;
        m_rr[i] = (m_rr[i] + 1) % 2;
    endfunction

    function automatic void m_flush(input bit with_rr);
        for (int i = 0; i < 64; i++) begin
            m_vld[i][0] = 1'b0;
            m_vld[i][1] = 1'b0;
            if (with_rr) m_rr[i] = 0;
        end
    endfunction

    // Per-cycle expectations, checked by the compare process at negedge.
    bit          chk = 1'b0;
    bit          e_v, e_m, e_r, e_z;
    logic [31:0] e_rd, e_sa;

    always @(negedge clk) begin
        if (chk) begin
            check("inst_valid", {63'd0, inst_valid}, {63'd0, e_v});
            check("cache_miss", {63'd0, cache_miss}, {63'd0, e_m});
            check("sram_req",   {63'd0, sram_req},   {63'd0, e_r});
            if (e_v || e_z) check("inst_rdata", {32'd0, inst_rdata}, {32'd0, e_rd});
            if (e_r || e_z) check("sram_addr",  {32'd0, sram_addr},  {32'd0, e_sa});
        end
    end

    task automatic ex(input bit v, input logic [31:0] rd, input bit m, input bit r,
                      input logic [31:0] sa, input bit z);
        e_v = v; e_rd = rd; e_m = m; e_r = r; e_sa = sa; e_z = z;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit fl);
        inst_en = 1'b0;
        flush = fl;
        ex(0, 0, 0, 0, 0, 0);
        tick;
        flush = 1'b0;
        if (fl) m_flush(0);
    endtask

    logic [63:0] fixed_beats[$];
    bit          in_lookup = 1'b0;

    // fmode: 0 normal, 1 flush after beat 0, 2 flush in REQ, 3 flush in LOOKUP,
    // 4 reset after beat 0, 5 five-cycle handshake stall, 6 flush on last beat.
    task automatic fetch(input logic [31:0] a, input int fmode, input bit chain,
                         input logic [31:0] ca, output bit was_hit, output logic [31:0] word);
        bit           h, drained;
        logic [31:0]  mw, la;
        logic [127:0] ln;
        logic [63:0]  beat;
        int           stall;
        la = a & ~32'hF;
        ln = '0;
        if (!in_lookup) begin
            inst_en = 1'b1; inst_addr = a; flush = 1'b0;
            ex(0, 0, 0, 0, 0, 0);
            tick;
        end
        in_lookup = 1'b0;
        h = m_lookup(a, mw);
        was_hit = h;
        word = mw;
        inst_en = chain; inst_addr = ca;
        if (fmode == 3) begin
            flush = 1'b1;
            ex(0, 0, 0, 0, 0, 0);
            tick;
            flush = 1'b0; inst_en = 1'b0;
            m_flush(0);
            return;
        end
        ex(h, mw, !h, 0, 0, 0);
        tick;
        inst_en = 1'b0;
        if (h) begin
            in_lookup = chain;
            return;
        end
        stall = (fmode == 5) ? 5 : $urandom_range(0, 2);
        for (int i = 0; i <= stall; i++) begin
            sram_ready = (i == stall);
            flush = (fmode == 2 && i == 0);
            ex(0, 0, 1, 1, la, 0);
            tick;
        end
        sram_ready = 1'b0; flush = 1'b0;
        drained = (fmode == 2);
        for (int b = 0; b < 2; b++) begin
            if (b == 1 && fmode == 4) begin
                reset = 1'b0;
                ex(0, 0, 0, 0, 0, 1);
                tick;
                reset = 1'b1;
                sram_valid = 1'b1; sram_rdata = {$urandom, $urandom};
                ex(0, 0, 0, 0, 0, 1);
                tick;
                sram_valid = 1'b0;
                m_flush(1);
                return;
            end
            if (b == 1 && fmode == 1) begin
                flush = 1'b1;
                ex(0, 0, 1, 0, 0, 0);
                tick;
                flush = 1'b0;
                drained = 1'b1;
            end
            repeat ($urandom_range(0, 2)) begin
                ex(0, 0, 1, 0, 0, 0);
                tick;
            end
            beat = (fixed_beats.size() > 0) ? fixed_beats.pop_front() : {$urandom, $urandom};
            ln[b*64 +: 64] = beat;
            sram_valid = 1'b1; sram_rdata = beat;
            flush = (fmode == 6 && b == 1);
            ex(0, 0, 1, 0, 0, 0);
            tick;
            sram_valid = 1'b0; flush = 1'b0;
        end
        if (drained || fmode == 6 || fmode == 1) begin
            m_flush(0);
            ex(0, 0, 0, 0, 0, 0);
            tick;
            return;
        end
        m_fill(a, ln);
        void'(m_lookup(a, mw));
        word = mw;
        ex(1, mw, 0, 0, 0, 0);
        tick;
    endtask

    function automatic logic [31:0] rand_addr();
        return 32'h8000_0000 | (32'($urandom_range(0, 3)) << 10) |
               (32'($urandom_range(0, 3)) << 4) | (32'($urandom_range(0, 3)) << 2);
    endfunction

    initial begin
        bit          h;
        logic [31:0] w, a, na, ca;
        int          fm, r;
        bit          ch;
        reset = 1'b0; flush = 1'b0; inst_en = 1'b0; inst_addr = '0;
        sram_ready = 1'b0; sram_valid = 1'b0; sram_rdata = '0;
        m_flush(1);
        tick;
        ex(0, 0, 0, 0, 0, 1);
        chk = 1'b1;
        tick;
        reset = 1'b1;
        idle(0);

        fixed_beats.push_back(64'h11112222_33334444);
        fixed_beats.push_back(64'h55556666_77778888);
        fetch(32'h8000_0004, 0, 0, 0, h, w);
        check("cold_hit", {63'd0, h}, 64'd0);
        check("cold_word", {32'd0, w}, 64'h11112222);
        fetch(32'h8000_0000, 0, 1, 32'h8000_000C, h, w);
        check("refetch_hit", {63'd0, h}, 64'd1);
        check("refetch_word", {32'd0, w}, 64'h33334444);
        fetch(32'h8000_000C, 0, 0, 0, h, w);
        check("chain_word", {32'd0, w}, 64'h55556666);

        fetch(32'h8000_0400, 0, 0, 0, h, w);
        fetch(32'h8000_0800, 0, 0, 0, h, w);
        fetch(32'h8000_0404, 0, 0, 0, h, w);
        check("repl_keep_way1", {63'd0, h}, 64'd1);
        fetch(32'h8000_0000, 0, 0, 0, h, w);
        check("repl_evict_way0", {63'd0, h}, 64'd0);

        fetch(32'h8000_1000, 5, 0, 0, h, w);
        check("stall_miss", {63'd0, h}, 64'd0);

        fetch(32'h8000_2000, 1, 0, 0, h, w);
        fetch(32'h8000_2000, 0, 0, 0, h, w);
        check("flush_refill_remiss", {63'd0, h}, 64'd0);
        fetch(32'h8000_2000, 3, 0, 0, h, w);
        fetch(32'h8000_2010, 2, 0, 0, h, w);
        fetch(32'h8000_2010, 6, 0, 0, h, w);
        fetch(32'h8000_2010, 0, 0, 0, h, w);
        check("flush_last_beat_remiss", {63'd0, h}, 64'd0);

        fetch(32'h8000_3000, 4, 0, 0, h, w);
        idle(0);
        fetch(32'h8000_3000, 0, 0, 0, h, w);
        check("reset_refill_remiss", {63'd0, h}, 64'd0);

        na = '0;
        for (int it = 0; it < 400; it++) begin
            a = in_lookup ? na : rand_addr();
            r = $urandom_range(0, 99);
            fm = in_lookup ? 0 : (r < 4) ? 1 : (r < 8) ? 2 : (r < 12) ? 3 :
                 (r < 15) ? 6 : (r < 17) ? 4 : 0;
            ch = (fm == 0) && ($urandom_range(0, 2) == 0);
            ca = rand_addr();
            fetch(a, fm, ch, ca, h, w);
            if (in_lookup) na = ca;
            else if ($urandom_range(0, 9) == 0) idle(1);
            else if ($urandom_range(0, 3) == 0) idle(0);
        end
        if (in_lookup) fetch(na, 0, 0, 0, h, w);
        idle(0);
        chk = 1'b0;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/ysyx_22041752_icache_nway.md
YSYX_22041752_ICACHE_NWAY -- requirements
Module: ysyx_22041752_ICACHE_NWAY

Interface
REQ-001 SHALL have parameter WAYS, default 2, associativity, power of two, 1..8.
REQ-002 SHALL have parameter SETS, default 64, sets per way, power of two, >=2.
REQ-003 SHALL have parameter LINE_BYTES, default 16, line size, power of two, >=8.
REQ-004 SHALL have parameter ADDR_WD, default 32, fetch/memory address width.
REQ-005 SHALL have parameter MEM_DATA_WD, default 64, refill beat width; BEATS = LINE_BYTES*8/MEM_DATA_WD, >=1.
REQ-006 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port flush, input, 1, invalidate all lines and squash the outstanding fetch.
REQ-009 SHALL have port inst_en, input, 1, fetch request.
REQ-010 SHALL have port inst_addr, input, ADDR_WD, fetch byte address, 4-byte aligned.
REQ-011 SHALL have port inst_rdata, output, 32, fetched instruction.
REQ-012 SHALL have port inst_valid, output, 1, inst_rdata valid this cycle.
REQ-013 SHALL have port cache_miss, output, 1, high while a miss is serviced; fetch stage stalls.
REQ-014 SHALL have port sram_req, output, 1, refill request.
REQ-015 SHALL have port sram_ready, input, 1, memory accepts the request.
REQ-016 SHALL have port sram_addr, output, ADDR_WD, line-aligned refill address.
REQ-017 SHALL have port sram_rdata, input, MEM_DATA_WD, refill beat data.
REQ-018 SHALL have port sram_valid, input, 1, beat valid; beats arrive in ascending address order.

Function
REQ-019 SHALL split the address as tag | index (log2 SETS bits) | offset (log2 LINE_BYTES bits).
REQ-020 SHALL implement FSM IDLE, LOOKUP, REQ, REFILL, RESP.
- IDLE -> LOOKUP on inst_en.
- LOOKUP hit: inst_valid=1 and inst_rdata driven this cycle, i.e. one cycle after inst_en. Go to LOOKUP if inst_en is high again, else IDLE.
- LOOKUP miss -> REQ.
REQ-021 SHALL hold sram_req=1 and sram_addr stable in REQ until sram_ready; the handshake cycle moves to REFILL.
REQ-022 SHALL in REFILL store one beat per sram_valid cycle, using a beat counter 0..BEATS-1; on the last beat, write data, tag and valid=1 to the victim way, then go to RESP.
REQ-023 SHALL in RESP assert inst_valid with the requested word from the refilled line, then go to IDLE.
REQ-024 SHALL hold cache_miss=1 from the LOOKUP-miss cycle through the REFILL last-beat cycle inclusive; inst_en is ignored while cache_miss=1.
REQ-025 SHALL select the victim as the lowest-index invalid way; if all ways are valid, use the set's round-robin pointer. The pointer increments modulo WAYS on every fill of that set.
REQ-026 SHALL on flush clear every valid bit in one cycle and suppress inst_valid that cycle.
- flush in LOOKUP or RESP: go to IDLE.
- flush in REQ: finish the request handshake.
- flush in REQ or REFILL: drain all BEATS beats without installing them or updating the pointer, then return to IDLE with no inst_valid.
REQ-027 SHALL, when flush and a last-beat install coincide, give flush priority; the line ends invalid.
REQ-028 SHALL never report a hit on a line whose valid bit is 0, whatever its tag.

Reset
REQ-029 SHALL on reset low asynchronously force: FSM=IDLE; all valid bits, round-robin pointers and beat counter 0; inst_valid, cache_miss and sram_req 0; inst_rdata and sram_addr 0.
REQ-030 SHALL, when reset is asserted mid-refill, abandon the refill and install nothing; beats arriving after release are ignored in IDLE.

Structure
REQ-031 SHALL keep the FSM state encoding, default parameter values and derived widths (OFFSET_WD, INDEX_WD, TAG_WD, BEAT_CNT_WD) in the shared ysyx_22041752 config header.
REQ-032 SHALL use one sub-module, ysyx_22041752_ICACHE_WAY: per-way tag, data and valid arrays with a 1-cycle read port and a line write port. It is instantiated WAYS times via generate.

Verification
REQ-033 Use defaults (WAYS=2, SETS=64, LINE_BYTES=16, BEATS=2) for all scenarios below.
REQ-034 Cold miss: fetch 0x8000_0004 -> sram_addr 0x8000_0000; beats 0x11112222_33334444 and 0x5555_6666_7777_8888; RESP gives inst_rdata 0x11112222; refetch 0x8000_0000 hits next cycle with 0x33334444.
REQ-035 Replacement: fill 0x8000_0000, 0x8000_0400, then 0x8000_0800 (all index 0) -> third fill evicts way 0; refetch 0x8000_0000 misses, 0x8000_0400 hits.
REQ-036 Handshake stall: hold sram_ready low for 5 cycles -> sram_req and sram_addr stable throughout, cache_miss=1, no inst_valid.
REQ-037 Flush mid-refill: flush after beat 0 -> beat 1 drained, no inst_valid; refetch of the same address misses again.
REQ-038 Reset mid-refill: reset low during REFILL -> all outputs 0 immediately; after release, a fetch of the same address misses.
